game_step_controller: RTL

- Sequential owner of the 2048 game state. It holds the registered board and score, and drives the combinational tile mover/merger with the current board and a latched direction.
- It consumes the merged board and score delta. It then commits the move, spawns a new tile, and evaluates win/lose.
- It sits between the debounced direction input logic (upstream) and the VGA renderer and score display (downstream).

---
 rtl/game2048_pkg.sv | 34 +++
 rtl/tile_lfsr.sv | 35 +++
 rtl/game_step_controller.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 game datapath: tile/board/score
// types, one-hot move directions, the step controller state encoding and
// the spawn LFSR feedback mask.
package game2048_pkg;

    typedef logic [11:0]      tile_t;
    typedef tile_t [3:0][3:0] board_t;   // indexed [row][col]
    typedef logic [19:0]      score_t;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam score_t      SCORE_MAX = 20'hFFFFF;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        INIT,
        READY,
        EVAL,
        SPAWN,
        CHECK,
        WON,
        LOST
    } state_e;

    // True only for the four legal one-hot direction codes.
    function automatic logic dir_is_one_hot(input logic [3:0] dir);
        return (dir == DIR_UP) || (dir == DIR_DOWN) ||
               (dir == DIR_LEFT) || (dir == DIR_RIGHT);
    endfunction

endpackage

// File: rtl/tile_lfsr.sv
// Free-running 16-bit Galois LFSR that supplies the spawn scan start cell
// and the 2-versus-4 choice for newly spawned tiles.
module tile_lfsr
    import game2048_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [3:0] ptr_o,
    output logic       four_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Right-shifting Galois step: feedback taps applied when the LSB falls out.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    end

    // State register; the seed must be nonzero or the sequence locks up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ptr_o  = lfsr_q[3:0];
    assign four_o = (lfsr_q[7:4] == 4'h0);

endmodule

// File: rtl/game_step_controller.sv
// Owner of the 2048 board and score. Feeds the combinational merge block,
// commits changed boards, spawns a tile by scanning from a random cell,
// then evaluates win/lose before accepting the next move.
module game_step_controller
    import game2048_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter tile_t       WIN_VALUE = 12'd2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       move_valid_i,
    input  logic [3:0] move_dir_i,
    input  logic       new_game_i,
    input  logic       load_i,
    input  board_t     load_board_i,
    output logic [3:0] mm_dir_o,
    output board_t     mm_board_o,
    input  board_t     mm_board_i,
    input  score_t     mm_score_i,
    output board_t     board_o,
    output score_t     score_o,
    output logic       busy_o,
    output logic       step_done_o,
    output logic       move_rejected_o,
    output logic       game_won_o,
    output logic       game_over_o
);

    // A board still has a legal move if any cell is empty or any two
    // orthogonal neighbours hold the same value.
    function automatic logic board_has_move(input board_t b);
        logic found;
        found = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (b[r][c] == '0) found = 1'b1;
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (b[r][c] == b[r][c+1]) found = 1'b1;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (b[r][c] == b[r+1][c]) found = 1'b1;
            end
        end
        return found;
    endfunction

    function automatic logic board_has_win(input board_t b, input tile_t win);
        logic found;
        found = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (b[r][c] == win) found = 1'b1;
            end
        end
        return found;
    endfunction

    state_e      state_q;
    board_t      board_q;
    score_t      score_q;
    logic [3:0]  dir_q;         // latched direction, nonzero only during EVAL
    logic [3:0]  ptr_q;         // spawn scan pointer, cell = row*4+col
    logic [3:0]  guard_q;       // cells tested so far in this spawn
    logic [1:0]  spawn_left_q;  // tiles still to place (2 in INIT, 1 after a move)
    logic        from_move_q;   // CHECK was reached through an accepted move
    logic        step_done_q;
    logic        rejected_q;
    logic        won_q;
    logic        over_q;

    logic [3:0]  rand_ptr;
    logic        rand_four;
    logic        cell_empty;
    tile_t       spawn_val;
    logic [20:0] score_sum;
    score_t      score_sat;

    tile_lfsr #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (1'b1),
        .ptr_o  (rand_ptr),
        .four_o (rand_four)
    );

    // Spawn cell test and saturating score accumulation.
    always_comb begin
        cell_empty = (board_q[ptr_q[3:2]][ptr_q[1:0]] == '0);
        spawn_val  = rand_four ? 12'd4 : 12'd2;
        score_sum  = {1'b0, score_q} + {1'b0, mm_score_i};
        score_sat  = score_sum[20] ? SCORE_MAX : score_sum[19:0];
    end

    // Game state machine; new_game_i beats load_i, which beats normal flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            board_q      <= '0;
            score_q      <= '0;
            dir_q        <= '0;
            ptr_q        <= '0;
            guard_q      <= '0;
            spawn_left_q <= '0;
            from_move_q  <= 1'b0;
            step_done_q  <= 1'b0;
            rejected_q   <= 1'b0;
            won_q        <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            step_done_q <= 1'b0;
            rejected_q  <= 1'b0;
            if (new_game_i) begin
                state_q      <= INIT;
                board_q      <= '0;
                score_q      <= '0;
                dir_q        <= '0;
                spawn_left_q <= '0;
                from_move_q  <= 1'b0;
                won_q        <= 1'b0;
                over_q       <= 1'b0;
            end else if (load_i) begin
                state_q     <= CHECK;
                board_q     <= load_board_i;
                dir_q       <= '0;
                from_move_q <= 1'b0;
                won_q       <= 1'b0;
                over_q      <= 1'b0;
            end else begin
                case (state_q)
                    INIT: begin
                        spawn_left_q <= 2'd2;
                        from_move_q  <= 1'b0;
                        ptr_q        <= rand_ptr;
                        guard_q      <= '0;
                        state_q      <= SPAWN;
                    end
                    READY: begin
                        if (move_valid_i && dir_is_one_hot(move_dir_i)) begin
                            dir_q   <= move_dir_i;
                            state_q <= EVAL;
                        end
                    end
                    EVAL: begin
                        dir_q <= '0;
                        if (mm_board_i != board_q) begin
                            board_q      <= mm_board_i;
                            score_q      <= score_sat;
                            from_move_q  <= 1'b1;
                            spawn_left_q <= 2'd1;
                            ptr_q        <= rand_ptr;
                            guard_q      <= '0;
                            state_q      <= SPAWN;
                        end else begin
                            rejected_q <= 1'b1;
                            state_q    <= READY;
                        end
                    end
                    SPAWN: begin
                        if (cell_empty) begin
                            board_q[ptr_q[3:2]][ptr_q[1:0]] <= spawn_val;
                            if (spawn_left_q == 2'd2) begin
                                // Second opening tile: restart the scan elsewhere.
                                spawn_left_q <= 2'd1;
                                ptr_q        <= rand_ptr;
                                guard_q      <= '0;
                            end else begin
                                spawn_left_q <= '0;
                                state_q      <= CHECK;
                            end
                        end else if (guard_q == 4'd15) begin
                            // Board is full: give up without writing.
                            spawn_left_q <= '0;
                            state_q      <= CHECK;
                        end else begin
                            ptr_q   <= ptr_q + 4'd1;
                            guard_q <= guard_q + 4'd1;
                        end
                    end
                    CHECK: begin
                        from_move_q <= 1'b0;
                        if (board_has_win(board_q, WIN_VALUE)) begin
                            won_q   <= 1'b1;
                            state_q <= WON;
                        end else if (!board_has_move(board_q)) begin
                            over_q  <= 1'b1;
                            state_q <= LOST;
                        end else begin
                            step_done_q <= from_move_q;
                            state_q     <= READY;
                        end
                    end
                    WON:     state_q <= WON;
                    LOST:    state_q <= LOST;
                    default: state_q <= INIT;
                endcase
            end
        end
    end

    assign mm_dir_o        = dir_q;
    assign mm_board_o      = board_q;
    assign board_o         = board_q;
    assign score_o         = score_q;
    assign busy_o          = (state_q != READY);
    assign step_done_o     = step_done_q;
    assign move_rejected_o = rejected_q;
    assign game_won_o      = won_q;
    assign game_over_o     = over_q;

endmodule
